obi_xbar_n_to_one_arb: RTL and testbench
========================================

// Module: obi_xbar_n_to_one_arb
// PURPOSE
//   Parametrised N-to-1 OBI arbiter for the external CPU subsystem master bus. Merges NMASTER
//   OBI managers (core instr/data, debug, peripheral ports) onto one OBI subordinate port.
//   Adds selectable fixed/round-robin arbitration, address-phase locking, per-master enable
//   mask and tracking of up to MAX_OUTSTANDING in-flight transactions with in-order response routing.
// PARAMETERS
//   NMASTER          4  number of manager ports (>=2)
//   MAX_OUTSTANDING  4  max granted-but-unanswered transactions (>=1)
//   ARB_MODE         1  0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//   clk_i            in   1                 clock
//   rst_ni           in   1                 async reset, active low
//   master_req_i     in   NMASTER x obi_req_t   manager requests (req, we, be, addr, wdata)
//   master_resp_o    out  NMASTER x obi_resp_t  per-manager gnt, rvalid, rdata
//   master_en_i      in   NMASTER           1 = manager may win arbitration
//   slave_req_o      out  obi_req_t         merged request to subordinate
//   slave_resp_i     in   obi_resp_t        subordinate gnt, rvalid, rdata
//   outstanding_o    out  $clog2(MAX_OUTSTANDING+1)  in-flight transaction count
//   spurious_err_o   out  1                 sticky: rvalid received with nothing outstanding
// BEHAVIOUR
//   Reset: lock cleared, RR pointer = 0, ID FIFO empty, outstanding_o = 0, spurious_err_o = 0;
//     slave_req_o all-zero and every master_resp_o.gnt/rvalid = 0 while no request is issued.
//   Eligible(i) = master_req_i[i].req & master_en_i[i]. Issue allowed only if outstanding_o < MAX_OUTSTANDING.
//   Address phase is combinational (0-cycle): slave_req_o = winner's request fields;
//     master_resp_o[winner].gnt = slave_resp_i.gnt; all other gnt = 0.
//   Winner selection (when not locked): ARB_MODE 0 -> lowest eligible index; ARB_MODE 1 ->
//     first eligible index at or after RR pointer, wrapping NMASTER-1 -> 0.
//   Lock FSM: IDLE / LOCKED. IDLE: slave_req_o.req=1 & gnt=0 -> LOCKED, store winner id.
//     LOCKED: winner forced to stored id regardless of other requests or master_en_i;
//     gnt=1 -> IDLE. Guarantees OBI address-phase stability at the subordinate.
//   Handshake (slave_req_o.req & slave_resp_i.gnt): push winner id into ID FIFO; if ARB_MODE 1,
//     RR pointer <= (winner+1) mod NMASTER. Pointer never moves without a handshake.
//   Full (outstanding_o == MAX_OUTSTANDING): slave_req_o.req = 0, no gnt to any master, even if
//     rvalid arrives the same cycle (no rvalid->req combinational path); issue resumes next cycle.
//   Response phase: slave_resp_i.rvalid with FIFO non-empty -> master_resp_o[head].rvalid = 1
//     same cycle, pop head. rdata broadcast to all master_resp_o.rdata; only head sees rvalid.
//   rvalid with FIFO empty: ignored (no master rvalid), spurious_err_o <= 1 until reset.
//   Push and pop same cycle: count unchanged, both applied; FIFO pointers wrap modulo MAX_OUTSTANDING.
//   Subordinate must answer in order; gnt and rvalid for different transactions may coincide.
//   Disabled master mid-lock: lock held until its gnt; then master excluded from arbitration.
//   Async reset mid-operation: all state cleared immediately; in-flight responses afterwards
//     count as spurious.
// TESTING
//   1 Single read: m0 req addr 0x1000, gnt same cycle, rvalid 2 cycles later rdata 0xDEADBEEF ->
//     m0 gnt, m0 rvalid with 0xDEADBEEF, outstanding_o 0->1->0.
//   2 Arbitration: m0..m3 request continuously, gnt=1 each cycle -> ARB_MODE 1 grants 0,1,2,3,0,1;
//     ARB_MODE 0 grants 0 every cycle.
//   3 Lock: m2 requests addr 0x2000, gnt held low 3 cycles, m0 requests at cycle 1 -> slave_req_o.addr
//     stays 0x2000 until gnt, m0 issued the following cycle.
//   4 Full: MAX_OUTSTANDING=4, four handshakes, no rvalid -> 5th request sees slave_req_o.req=0 and
//     gnt=0; one rvalid -> issue resumes next cycle, outstanding_o returns to 4.
//   5 Routing: handshakes m1, m3, m0, then rvalids rdata 0x11, 0x33, 0x00 -> rvalid on m1, m3, m0
//     in that order, no rvalid on other masters.
//   6 Mask/spurious: master_en_i=4'b1110, m0 requests -> never granted; rvalid with outstanding_o=0
//     -> no master rvalid, spurious_err_o=1 and held until rst_ni low.

Source files
------------

// File: rtl/obi_xbar_n_to_one_arb.sv
// N-to-1 OBI arbiter: merges NMASTER managers onto one subordinate port.
// The address phase is combinational. A lock holds a stalled request stable until it is
// granted. Up to MAX_OUTSTANDING transactions are tracked in an ID FIFO, and responses
// are routed back to their managers in issue order.
module obi_xbar_n_to_one_arb #(
  parameter int NMASTER         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  // manager side, flattened per-master fields
  input  logic [NMASTER-1:0]                   master_req_i,
  input  logic [NMASTER-1:0]                   master_we_i,
  input  logic [NMASTER*4-1:0]                 master_be_i,
  input  logic [NMASTER*32-1:0]                master_addr_i,
  input  logic [NMASTER*32-1:0]                master_wdata_i,
  output logic [NMASTER-1:0]                   master_gnt_o,
  output logic [NMASTER-1:0]                   master_rvalid_o,
  output logic [NMASTER*32-1:0]                master_rdata_o,
  input  logic [NMASTER-1:0]                   master_en_i,
  // subordinate side
  output logic                                 slave_req_o,
  output logic                                 slave_we_o,
  output logic [3:0]                           slave_be_o,
  output logic [31:0]                          slave_addr_o,
  output logic [31:0]                          slave_wdata_o,
  input  logic                                 slave_gnt_i,
  input  logic                                 slave_rvalid_i,
  input  logic [31:0]                          slave_rdata_i,
  // status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 spurious_err_o
);

  localparam int IDW = $clog2(NMASTER);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {IDLE, LOCKED} lock_e;

  lock_e            lock_q, lock_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   fifo_q [MAX_OUTSTANDING];
  logic [IDW-1:0]   fifo_d [MAX_OUTSTANDING];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             spur_q, spur_d;

  logic [NMASTER-1:0] elig;
  logic [IDW-1:0]     win_id;
  logic               win_vld;
  logic               full, issue, push, pop;

  // Index k positions after the round-robin pointer, wrapping at NMASTER.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    return IDW'((int'(p) + k) % NMASTER);
  endfunction

  // FIFO pointer increment with wrap at MAX_OUTSTANDING.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  assign elig  = master_req_i & master_en_i;
  assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign issue = win_vld & ~full;
  assign push  = issue & slave_gnt_i;
  assign pop   = slave_rvalid_i & (cnt_q != '0);

  // Winner selection: a locked request wins unconditionally, otherwise fixed or round-robin.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    if (lock_q == LOCKED) begin
      win_id  = lock_id_q;
      win_vld = master_req_i[lock_id_q];
    end else if (ARB_MODE == 0) begin
      for (int i = NMASTER - 1; i >= 0; i--) begin
        if (elig[i]) begin
          win_vld = 1'b1;
          win_id  = IDW'(i);
        end
      end
    end else begin
      // Scan downward so the candidate closest to the pointer is the last one assigned.
      for (int k = NMASTER - 1; k >= 0; k--) begin
        if (elig[rr_idx(rr_q, k)]) begin
          win_vld = 1'b1;
          win_id  = rr_idx(rr_q, k);
        end
      end
    end
  end

  // Address-phase mux toward the subordinate and grant return to the winner.
  always_comb begin
    slave_req_o   = issue;
    slave_we_o    = 1'b0;
    slave_be_o    = '0;
    slave_addr_o  = '0;
    slave_wdata_o = '0;
    master_gnt_o  = '0;
    if (issue) begin
      slave_we_o           = master_we_i[win_id];
      slave_be_o           = master_be_i[int'(win_id)*4 +: 4];
      slave_addr_o         = master_addr_i[int'(win_id)*32 +: 32];
      slave_wdata_o        = master_wdata_i[int'(win_id)*32 +: 32];
      master_gnt_o[win_id] = slave_gnt_i;
    end
  end

  // Response routing: rdata goes to every manager, but only the FIFO head sees rvalid.
  always_comb begin
    master_rdata_o  = {NMASTER{slave_rdata_i}};
    master_rvalid_o = '0;
    if (pop) master_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
  end

  // Next-state for the lock FSM, round-robin pointer, ID FIFO and error flag.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_d      = rr_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    spur_d    = spur_q | (slave_rvalid_i & (cnt_q == '0));
    case (lock_q)
      IDLE:    if (issue && !slave_gnt_i) begin
                 lock_d    = LOCKED;
                 lock_id_d = win_id;
               end
      LOCKED:  if (push) lock_d = IDLE;
      default: lock_d = IDLE;
    endcase
    if (push) begin
      fifo_d[wr_ptr_q] = win_id;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      if (ARB_MODE == 1) rr_d = (int'(win_id) == NMASTER - 1) ? '0 : win_id + 1'b1;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; asynchronous reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= IDLE;
      lock_id_q <= '0;
      rr_q      <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      spur_q    <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_q      <= rr_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      spur_q    <= spur_d;
    end
  end

  assign outstanding_o  = cnt_q;
  assign spurious_err_o = spur_q;

endmodule

// File: tb/tb_obi_xbar_n_to_one_arb.sv
// Directed bench for obi_xbar_n_to_one_arb (4 masters, 4 outstanding).
// A round-robin instance is checked everywhere; a fixed-priority instance shares the
// inputs and is checked only in the arbitration scenario.
module tb_obi_xbar_n_to_one_arb;
  localparam int NM = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NM-1:0]   m_req, m_we, m_en;
  logic [NM*4-1:0] m_be;
  logic [NM*32-1:0] m_addr, m_wdata;
  logic            s_gnt, s_rvalid;
  logic [31:0]     s_rdata;

  logic [NM-1:0]    gnt1, rv1, gnt0, rv0;
  logic [NM*32-1:0] rd1, rd0;
  logic             sreq1, swe1, sreq0, swe0;
  logic [3:0]       sbe1, sbe0;
  logic [31:0]      saddr1, swd1, saddr0, swd0;
  logic [2:0]       out1, out0;
  logic             spur1, spur0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  obi_xbar_n_to_one_arb #(.NMASTER(NM), .MAX_OUTSTANDING(4), .ARB_MODE(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .master_req_i(m_req), .master_we_i(m_we), .master_be_i(m_be),
    .master_addr_i(m_addr), .master_wdata_i(m_wdata),
    .master_gnt_o(gnt1), .master_rvalid_o(rv1), .master_rdata_o(rd1),
    .master_en_i(m_en),
    .slave_req_o(sreq1), .slave_we_o(swe1), .slave_be_o(sbe1),
    .slave_addr_o(saddr1), .slave_wdata_o(swd1),
    .slave_gnt_i(s_gnt), .slave_rvalid_i(s_rvalid), .slave_rdata_i(s_rdata),
    .outstanding_o(out1), .spurious_err_o(spur1)
  );

  obi_xbar_n_to_one_arb #(.NMASTER(NM), .MAX_OUTSTANDING(4), .ARB_MODE(0)) dut_fixed (
    .clk_i(clk), .rst_ni(rst_n),
    .master_req_i(m_req), .master_we_i(m_we), .master_be_i(m_be),
    .master_addr_i(m_addr), .master_wdata_i(m_wdata),
    .master_gnt_o(gnt0), .master_rvalid_o(rv0), .master_rdata_o(rd0),
    .master_en_i(m_en),
    .slave_req_o(sreq0), .slave_we_o(swe0), .slave_be_o(sbe0),
    .slave_addr_o(saddr0), .slave_wdata_o(swd0),
    .slave_gnt_i(s_gnt), .slave_rvalid_i(s_rvalid), .slave_rdata_i(s_rdata),
    .outstanding_o(out0), .spurious_err_o(spur0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance just past the next rising edge; inputs are then changed for the new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to mid-cycle, where outputs are sampled.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
    m_en = '1; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic set_m(input int m, input logic req, input logic [31:0] addr);
    m_req[m]          = req;
    m_addr[m*32 +: 32] = addr;
    m_be[m*4 +: 4]     = 4'hF;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    mid();
    // reset state
    check("rst_outstanding", 32'(out1), 0);
    check("rst_slave_req", 32'(sreq1), 0);
    check("rst_slave_addr", saddr1, 0);
    check("rst_spurious", 32'(spur1), 0);
    check("rst_gnt", 32'(gnt1), 0);
    check("rst_rvalid", 32'(rv1), 0);
    cyc();
    rst_n = 1'b1;

    // 1 single read from m0
    cyc();
    set_m(0, 1'b1, 32'h1000); s_gnt = 1'b1;
    mid();
    check("t1_req", 32'(sreq1), 1);
    check("t1_addr", saddr1, 32'h1000);
    check("t1_be", 32'(sbe1), 32'hF);
    check("t1_gnt", 32'(gnt1), 32'b0001);
    check("t1_out0", 32'(out1), 0);
    cyc();
    set_m(0, 1'b0, 32'h0); s_gnt = 1'b0;
    mid();
    check("t1_out1", 32'(out1), 1);
    check("t1_idle_req", 32'(sreq1), 0);
    cyc();
    s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
    mid();
    check("t1_rvalid", 32'(rv1), 32'b0001);
    check("t1_rdata", rd1[31:0], 32'hDEADBEEF);
    cyc();
    s_rvalid = 1'b0;
    mid();
    check("t1_out_end", 32'(out1), 0);

    // 2 all masters requesting, gnt every cycle, rvalid one cycle behind
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int m = 0; m < NM; m++) set_m(m, 1'b1, 32'h100 * (m + 1));
      s_gnt = 1'b1;
      s_rvalid = (k > 0);
      mid();
      check($sformatf("t2_rr_gnt%0d", k), 32'(gnt1), 32'(1 << (k % 4)));
      check($sformatf("t2_fix_gnt%0d", k), 32'(gnt0), 32'b0001);
      if (k > 0) check($sformatf("t2_rr_rv%0d", k), 32'(rv1), 32'(1 << ((k - 1) % 4)));
      cyc();
    end
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
    cyc();
    s_rvalid = 1'b0;
    mid();
    check("t2_out_end", 32'(out1), 0);
    check("t2_fix_out_end", 32'(out0), 0);
    check("t2_spur", 32'(spur1), 0);

    // 3 address-phase lock on m2 while m0 joins
    do_reset();
    set_m(2, 1'b1, 32'h2000);
    mid();
    check("t3_c0_addr", saddr1, 32'h2000);
    check("t3_c0_gnt", 32'(gnt1), 0);
    cyc();
    set_m(0, 1'b1, 32'h0A00);
    mid();
    check("t3_c1_addr", saddr1, 32'h2000);
    cyc();
    mid();
    check("t3_c2_addr", saddr1, 32'h2000);
    cyc();
    s_gnt = 1'b1;
    mid();
    check("t3_c3_addr", saddr1, 32'h2000);
    check("t3_c3_gnt", 32'(gnt1), 32'b0100);
    cyc();
    set_m(2, 1'b0, 32'h0);
    mid();
    check("t3_c4_addr", saddr1, 32'h0A00);
    check("t3_c4_gnt", 32'(gnt1), 32'b0001);
    cyc();
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
    mid();
    check("t3_rv_m2", 32'(rv1), 32'b0100);
    cyc();
    mid();
    check("t3_rv_m0", 32'(rv1), 32'b0001);
    cyc();
    s_rvalid = 1'b0;

    // 4 full condition
    do_reset();
    set_m(1, 1'b1, 32'h3000); s_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      check($sformatf("t4_out%0d", k), 32'(out1), 32'(k));
      cyc();
    end
    mid();
    check("t4_full_out", 32'(out1), 4);
    check("t4_full_req", 32'(sreq1), 0);
    check("t4_full_gnt", 32'(gnt1), 0);
    cyc();
    s_rvalid = 1'b1;
    mid();
    check("t4_rv_req", 32'(sreq1), 0);
    check("t4_rv_gnt", 32'(gnt1), 0);
    check("t4_rv_route", 32'(rv1), 32'b0010);
    cyc();
    s_rvalid = 1'b0;
    mid();
    check("t4_resume_req", 32'(sreq1), 1);
    check("t4_resume_gnt", 32'(gnt1), 32'b0010);
    check("t4_resume_out", 32'(out1), 3);
    cyc();
    mid();
    check("t4_refull_out", 32'(out1), 4);
    check("t4_refull_req", 32'(sreq1), 0);
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    s_rvalid = 1'b0;
    mid();
    check("t4_drain_out", 32'(out1), 0);

    // 5 in-order response routing m1, m3, m0
    do_reset();
    s_gnt = 1'b1;
    set_m(1, 1'b1, 32'h10);
    cyc();
    set_m(1, 1'b0, 32'h0); set_m(3, 1'b1, 32'h30);
    cyc();
    set_m(3, 1'b0, 32'h0); set_m(0, 1'b1, 32'h00);
    cyc();
    m_req = '0; s_gnt = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h11;
    mid();
    check("t5_out3", 32'(out1), 3);
    check("t5_rv_m1", 32'(rv1), 32'b0010);
    check("t5_rd_m1", rd1[63:32], 32'h11);
    cyc();
    s_rdata = 32'h33;
    mid();
    check("t5_rv_m3", 32'(rv1), 32'b1000);
    check("t5_rd_m3", rd1[127:96], 32'h33);
    cyc();
    s_rdata = 32'h00;
    mid();
    check("t5_rv_m0", 32'(rv1), 32'b0001);
    cyc();
    s_rvalid = 1'b0;
    mid();
    check("t5_out_end", 32'(out1), 0);

    // 6 enable mask and spurious response
    do_reset();
    m_en = 4'b1110;
    set_m(0, 1'b1, 32'h4000); s_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      check($sformatf("t6_masked_req%0d", k), 32'(sreq1), 0);
      check($sformatf("t6_masked_gnt%0d", k), 32'(gnt1), 0);
      cyc();
    end
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
    mid();
    check("t6_spur_rv", 32'(rv1), 0);
    check("t6_spur_pre", 32'(spur1), 0);
    cyc();
    s_rvalid = 1'b0;
    mid();
    check("t6_spur_set", 32'(spur1), 1);
    check("t6_spur_out", 32'(out1), 0);
    cyc();
    cyc();
    mid();
    check("t6_spur_hold", 32'(spur1), 1);
    rst_n = 1'b0;
    #1;
    check("t6_spur_clr", 32'(spur1), 0);
    cyc();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
